// File: rtl/asi_arb.sv
// asi_arb: lends one single-port SRAM to the write or the read user side for a whole burst and muxes its beats onto the memory port.
// Latency: grant 1 cycle after a sampled request, beats pass combinationally to memory, r_rvalid follows a read issue by RD_LAT cycles.
// Backpressure: none inside a burst; the other side holds its req until granted, and any beat from a side without its grant is dropped and flagged.
module asi_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int STRB_W = DATA_W / 8,
    parameter int RD_LAT = 1
) (
    input  logic              usr_clk,
    input  logic              usr_reset_n,
    // write-side user interface
    input  logic              w_req,
    output logic              w_gnt,
    input  logic              w_we,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic [STRB_W-1:0] w_strb,
    input  logic              w_last,
    // read-side user interface
    input  logic              r_req,
    output logic              r_gnt,
    input  logic              r_re,
    input  logic [ADDR_W-1:0] r_addr,
    input  logic              r_last,
    output logic [DATA_W-1:0] r_rdata,
    output logic              r_rvalid,
    // memory macro port
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic [DATA_W-1:0] mem_rdata,
    // protocol error pulse
    output logic              gnt_err
);

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WR   = 2'd1,
        ARB_RD   = 2'd2
    } arb_state_t;

    typedef enum logic {
        SRV_WR = 1'b0,
        SRV_RD = 1'b1
    } srv_t;

    arb_state_t        state;
    srv_t              last_srv;
    logic [RD_LAT-1:0] rd_pipe;
    logic              rd_issue;
    logic              w_done;
    logic              r_done;

    // A burst ends on its last beat or when the requester gives up its req.
    assign w_done = (w_we && w_last) || !w_req;
    assign r_done = (r_re && r_last) || !r_req;

    // Burst-level arbitration; ties go to the side that was not served last, and every burst end costs one idle cycle.
    always_ff @(posedge usr_clk) begin
        if (!usr_reset_n) begin
            state    <= ARB_IDLE;
            last_srv <= SRV_RD;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (w_req && (!r_req || last_srv == SRV_RD)) begin
                        state    <= ARB_WR;
                        last_srv <= SRV_WR;
                    end else if (r_req) begin
                        state    <= ARB_RD;
                        last_srv <= SRV_RD;
                    end
                end
                ARB_WR: begin
                    if (w_done) begin
                        state <= ARB_IDLE;
                    end
                end
                ARB_RD: begin
                    if (r_done) begin
                        state <= ARB_IDLE;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    // Grants come straight off the state register so they can never overlap or glitch.
    assign w_gnt = (state == ARB_WR);
    assign r_gnt = (state == ARB_RD);

    // Memory port mux: only the granted side reaches the macro, everything is quiet when idle.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        case (state)
            ARB_WR: begin
                mem_en    = w_we;
                mem_we    = 1'b1;
                mem_addr  = w_addr;
                mem_wdata = w_data;
                mem_wstrb = w_strb;
            end
            ARB_RD: begin
                mem_en    = r_re;
                mem_addr  = r_addr;
            end
            default: begin
                mem_en    = 1'b0;
            end
        endcase
    end

    assign rd_issue = mem_en && !mem_we;

    // Read-valid shift register matching the macro latency; it keeps draining after the grant moves on.
    always_ff @(posedge usr_clk) begin
        if (!usr_reset_n) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe[0] <= rd_issue;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    assign r_rvalid = rd_pipe[RD_LAT-1];
    assign r_rdata  = mem_rdata;

    // Flag a beat strobe from a side that does not own the memory; the mux has already kept it off the port.
    always_ff @(posedge usr_clk) begin
        if (!usr_reset_n) begin
            gnt_err <= 1'b0;
        end else begin
            gnt_err <= (w_we && (state != ARB_WR)) || (r_re && (state != ARB_RD));
        end
    end

endmodule

// File: tb/tb_asi_arb.sv
// tb_asi_arb: directed scenarios plus randomized bursts against a burst-level behavioural model and an SRAM model.
// Latency: model tracks grant owner per cycle and a queue of pending read returns due RD_LAT cycles after issue.
// Backpressure: drivers hold req until granted; occasional aborts, off-grant beats and resets are injected.
module tb_asi_arb;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int STRB_W = 8;
    localparam int RD_LAT = 2;

    logic              usr_clk = 1'b0;
    logic              usr_reset_n = 1'b0;
    logic              w_req = 1'b0, w_we = 1'b0, w_last = 1'b0;
    logic [ADDR_W-1:0] w_addr = '0;
    logic [DATA_W-1:0] w_data = '0;
    logic [STRB_W-1:0] w_strb = '0;
    logic              r_req = 1'b0, r_re = 1'b0, r_last = 1'b0;
    logic [ADDR_W-1:0] r_addr = '0;
    logic              w_gnt, r_gnt, r_rvalid, gnt_err;
    logic [DATA_W-1:0] r_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic [DATA_W-1:0] mem_rdata;

    asi_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W), .RD_LAT(RD_LAT)) dut (
        .usr_clk(usr_clk), .usr_reset_n(usr_reset_n),
        .w_req(w_req), .w_gnt(w_gnt), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .w_strb(w_strb), .w_last(w_last),
        .r_req(r_req), .r_gnt(r_gnt), .r_re(r_re), .r_addr(r_addr), .r_last(r_last),
        .r_rdata(r_rdata), .r_rvalid(r_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .gnt_err(gnt_err)
    );

    always #5 usr_clk = ~usr_clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- SRAM macro model (driven by the DUT memory port) ----------------
    logic [DATA_W-1:0] sram [0:127];
    logic [DATA_W-1:0] smem [0:127];
    logic [DATA_W-1:0] rpipe [RD_LAT];
    logic              s_en, s_we;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wd;
    logic [STRB_W-1:0] s_st;

    initial begin
        for (int i = 0; i < 128; i++) begin
            sram[i] = {32'h5EED_0000 | 32'(i), 32'hFACE_0000 | 32'(i)};
            smem[i] = sram[i];
        end
        for (int i = 0; i < RD_LAT; i++) rpipe[i] = '0;
    end

    always @(negedge usr_clk) begin
        s_en = mem_en; s_we = mem_we; s_addr = mem_addr; s_wd = mem_wdata; s_st = mem_wstrb;
    end

    always @(posedge usr_clk) begin
        for (int i = RD_LAT - 1; i > 0; i--) rpipe[i] <= rpipe[i-1];
        rpipe[0] <= (s_en === 1'b1 && s_we === 1'b0) ? sram[s_addr[9:3]] : '0;
        if (s_en === 1'b1 && s_we === 1'b1)
            for (int b = 0; b < STRB_W; b++)
                if (s_st[b]) sram[s_addr[9:3]][b*8 +: 8] <= s_wd[b*8 +: 8];
    end

    assign mem_rdata = rpipe[RD_LAT-1];

    // ---------------- behavioural model ----------------
    int                m_own = 0;        // 0 nobody, 1 write side, 2 read side
    bit                m_wr_last = 1'b0; // write side was granted most recently
    bit                m_err = 1'b0;
    int                due_q[$];
    logic [DATA_W-1:0] dat_q[$];

    always @(posedge usr_clk) begin
        int e;
        e = cyc;
        // the macro commits whatever reaches its port, even in the reset cycle
        if (m_own == 1 && w_we)
            for (int b = 0; b < STRB_W; b++)
                if (w_strb[b]) smem[w_addr[9:3]][b*8 +: 8] = w_data[b*8 +: 8];
        if (!usr_reset_n) begin
            m_own = 0; m_wr_last = 1'b0; m_err = 1'b0;
            due_q.delete(); dat_q.delete();
        end else begin
            m_err = (w_we && m_own != 1) || (r_re && m_own != 2);
            if (m_own == 2 && r_re) begin
                due_q.push_back(e + RD_LAT);
                dat_q.push_back(smem[r_addr[9:3]]);
            end
            if (m_own == 0) begin
                if (w_req && (!r_req || !m_wr_last)) begin m_own = 1; m_wr_last = 1'b1; end
                else if (r_req) begin m_own = 2; m_wr_last = 1'b0; end
            end else if (m_own == 1) begin
                if ((w_we && w_last) || !w_req) m_own = 0;
            end else begin
                if ((r_re && r_last) || !r_req) m_own = 0;
            end
        end
        cyc = e + 1;
        while (due_q.size() > 0 && due_q[0] < cyc) begin
            void'(due_q.pop_front());
            void'(dat_q.pop_front());
        end
    end

    // Every cycle: compare all DUT outputs with the model.
    always @(negedge usr_clk) begin
        if (chk_en) begin
            logic              x_en, x_we, x_rv;
            logic [ADDR_W-1:0] x_addr;
            logic [DATA_W-1:0] x_wd;
            logic [STRB_W-1:0] x_st;
            x_en = 1'b0; x_we = 1'b0; x_addr = '0; x_wd = '0; x_st = '0;
            if (m_own == 1) begin
                x_en = w_we; x_we = 1'b1; x_addr = w_addr; x_wd = w_data; x_st = w_strb;
            end else if (m_own == 2) begin
                x_en = r_re; x_addr = r_addr;
            end
            x_rv = (due_q.size() > 0 && due_q[0] == cyc);
            check("w_gnt", 64'(w_gnt), 64'(m_own == 1));
            check("r_gnt", 64'(r_gnt), 64'(m_own == 2));
            check("mem_en", 64'(mem_en), 64'(x_en));
            check("mem_we", 64'(mem_we), 64'(x_we));
            check("mem_addr", 64'(mem_addr), 64'(x_addr));
            check("mem_wdata", mem_wdata, x_wd);
            check("mem_wstrb", 64'(mem_wstrb), 64'(x_st));
            check("gnt_err", 64'(gnt_err), 64'(m_err));
            check("r_rvalid", 64'(r_rvalid), 64'(x_rv));
            if (x_rv) check("r_rdata", r_rdata, dat_q[0]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge usr_clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge usr_clk);
    endtask

    task automatic quiet();
        w_req = 0; w_we = 0; w_last = 0; r_req = 0; r_re = 0; r_last = 0;
        w_strb = 8'hFF;
    endtask

    int req_s[2], left_s[2], base_s[2], idx_s[2], started_s[2];

    task automatic rand_cycle();
        bit g[2];
        bit bt[2];
        bit ls[2];
        int wd[2];
        g[0] = w_gnt; g[1] = r_gnt;
        for (int s = 0; s < 2; s++) begin
            bt[s] = 0; ls[s] = 0; wd[s] = int'($urandom % 128);
            if (left_s[s] == 0) begin
                req_s[s] = ($urandom % 3 == 0) ? 1 : 0;
                if (req_s[s] != 0) begin
                    left_s[s] = $urandom_range(1, 4); base_s[s] = int'($urandom % 128);
                    idx_s[s] = 0; started_s[s] = 0;
                end else if ($urandom % 20 == 0) begin
                    bt[s] = 1; ls[s] = 1'($urandom % 2);
                end
            end else if (!g[s]) begin
                if (started_s[s] != 0) begin
                    req_s[s] = 0; left_s[s] = 0; started_s[s] = 0;
                end else if ($urandom % 24 == 0) begin
                    bt[s] = 1; ls[s] = 1'($urandom % 2);
                end
            end else begin
                started_s[s] = 1;
                if ($urandom % 30 == 0) begin
                    req_s[s] = 0; left_s[s] = 0; started_s[s] = 0;
                end else if ($urandom % 4 != 0) begin
                    bt[s] = 1; ls[s] = (left_s[s] == 1);
                    wd[s] = (base_s[s] + idx_s[s]) % 128;
                    idx_s[s]++; left_s[s]--;
                    if (left_s[s] == 0) started_s[s] = 0;
                end
            end
        end
        w_req = req_s[0][0]; w_we = bt[0]; w_last = ls[0]; w_addr = ADDR_W'(wd[0] * 8);
        w_data = {$urandom, $urandom}; w_strb = STRB_W'($urandom);
        r_req = req_s[1][0]; r_re = bt[1]; r_last = ls[1]; r_addr = ADDR_W'(wd[1] * 8);
        usr_reset_n = ($urandom % 400 != 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int own, bno;
        int exp_seq[11];
        exp_seq = '{1, 1, 0, 2, 2, 0, 1, 1, 0, 2, 2};
        quiet();
        tick(); tick();
        chk_en = 1'b1;
        // reset state
        at_neg();
        check("rst w_gnt", 64'(w_gnt), 64'd0);
        check("rst r_gnt", 64'(r_gnt), 64'd0);
        check("rst mem_en", 64'(mem_en), 64'd0);
        check("rst r_rvalid", 64'(r_rvalid), 64'd0);
        tick();
        usr_reset_n = 1;
        tick();

        // single 4-beat write burst
        w_req = 1;
        tick();
        for (int b = 0; b < 4; b++) begin
            w_we = 1; w_addr = ADDR_W'(b * 8); w_data = 64'hA0 + 64'(b); w_last = (b == 3);
            at_neg();
            check("wr w_gnt", 64'(w_gnt), 64'd1);
            check("wr mem_en", 64'(mem_en), 64'd1);
            check("wr mem_we", 64'(mem_we), 64'd1);
            check("wr mem_addr", 64'(mem_addr), 64'(b * 8));
            check("wr mem_wdata", mem_wdata, 64'hA0 + 64'(b));
            tick();
        end
        w_we = 0; w_last = 0; w_req = 0;
        at_neg();
        check("wr gnt drop", 64'(w_gnt), 64'd0);
        tick();

        // tie held continuously after reset: WR, RD, WR, RD with one idle between
        usr_reset_n = 0;
        tick();
        usr_reset_n = 1; w_req = 1; r_req = 1;
        tick();
        bno = 0;
        for (int i = 0; i < 11; i++) begin
            own = w_gnt ? 1 : (r_gnt ? 2 : 0);
            if (own == 0) bno = 0;
            w_we = (own == 1); r_re = (own == 2);
            w_last = (own == 1 && bno == 1); r_last = (own == 2 && bno == 1);
            w_addr = ADDR_W'(32'h100 + 8 * i); w_data = 64'(i); r_addr = ADDR_W'(32'h180 + 8 * i);
            if (own != 0) bno++;
            at_neg();
            check("tie order", 64'(own), 64'(exp_seq[i]));
            tick();
        end
        quiet();
        tick(); tick(); tick();

        // read latency: read of 0x40 returns exactly RD_LAT cycles later
        r_req = 1;
        tick();
        r_re = 1; r_addr = 32'h40; r_last = 1;
        at_neg();
        check("lat issue rvalid", 64'(r_rvalid), 64'd0);
        tick();
        r_re = 0; r_last = 0; r_req = 0;
        at_neg();
        check("lat +1 rvalid", 64'(r_rvalid), 64'd0);
        tick();
        at_neg();
        check("lat +2 rvalid", 64'(r_rvalid), 64'd1);
        check("lat +2 rdata", r_rdata, 64'h5EED0008_FACE0008);
        tick();
        at_neg();
        check("lat +3 rvalid", 64'(r_rvalid), 64'd0);
        tick();

        // read burst ends while the write side waits; returns land under w_gnt
        r_req = 1;
        tick();
        w_req = 1; r_re = 1; r_addr = 32'h48; r_last = 0;
        at_neg();
        check("sw r_gnt", 64'(r_gnt), 64'd1);
        tick();
        r_addr = 32'h50; r_last = 1;
        tick();
        r_re = 0; r_last = 0; r_req = 0;
        at_neg();
        check("sw idle w_gnt", 64'(w_gnt), 64'd0);
        check("sw beat1 rvalid", 64'(r_rvalid), 64'd1);
        check("sw beat1 rdata", r_rdata, 64'h5EED0009_FACE0009);
        tick();
        w_we = 1; w_last = 1; w_addr = 32'h200; w_data = 64'h1234;
        at_neg();
        check("sw w_gnt", 64'(w_gnt), 64'd1);
        check("sw beat2 rvalid", 64'(r_rvalid), 64'd1);
        check("sw beat2 rdata", r_rdata, 64'h5EED000A_FACE000A);
        tick();
        quiet();
        tick();

        // read strobe during a write grant
        w_req = 1;
        tick();
        w_we = 1; w_last = 0; w_addr = 32'h208; r_re = 1; r_addr = 32'h60;
        at_neg();
        check("err mem_we", 64'(mem_we), 64'd1);
        check("err mem_addr", 64'(mem_addr), 64'h208);
        tick();
        r_re = 0; w_addr = 32'h210; w_last = 1;
        at_neg();
        check("err pulse", 64'(gnt_err), 64'd1);
        tick();
        quiet();
        at_neg();
        check("err clear", 64'(gnt_err), 64'd0);
        check("err no read", 64'(r_rvalid), 64'd0);
        tick();

        // reset on beat 2 of a read burst, both sides requesting through reset
        r_req = 1;
        tick();
        r_re = 1; r_addr = 32'h0;
        tick();
        r_addr = 32'h8; usr_reset_n = 0; w_req = 1;
        tick();
        usr_reset_n = 1; r_re = 0;
        at_neg();
        check("mrst r_gnt", 64'(r_gnt), 64'd0);
        check("mrst r_rvalid", 64'(r_rvalid), 64'd0);
        check("mrst mem_en", 64'(mem_en), 64'd0);
        tick();
        at_neg();
        check("mrst tie to wr", 64'(w_gnt), 64'd1);
        tick();
        quiet();
        tick(); tick(); tick();

        // randomized traffic
        for (int i = 0; i < 2; i++) begin
            req_s[i] = 0; left_s[i] = 0; base_s[i] = 0; idx_s[i] = 0; started_s[i] = 0;
        end
        for (int n = 0; n < 3000; n++) begin
            rand_cycle();
            tick();
        end
        quiet();
        usr_reset_n = 1;
        repeat (6) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
